dm_arbiter: RTL and testbench

Data-memory access controller between the pipeline's MEM stage and a single-port synchronous data RAM (1-cycle read latency). It shares the RAM between the CPU data port and the boot/debug loader port. It also sequences each access through issue and response cycles, and generates byte enables and lane-replicated write data. Loads are returned sign- or zero-extended by `wordmode`, with misaligned CPU accesses flagged as errors.

---
 rtl/dm_arbiter_pkg.sv | 33 +++
 rtl/dm_arbiter_lane_unit.sv | 65 ++++++
 rtl/dm_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dm_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared definitions for the data-memory arbiter slice.
//   - wordmode encodings for CPU accesses
//   - FSM state encoding
//   - access source IDs
//   - norm_wordmode(): maps any unknown wordmode encoding to wm_bu
package dm_arbiter_pkg;

  localparam logic [2:0] wm_wd = 3'd0;
  localparam logic [2:0] wm_hu = 3'd1;
  localparam logic [2:0] wm_hs = 3'd2;
  localparam logic [2:0] wm_bu = 3'd3;
  localparam logic [2:0] wm_bs = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  // Encodings 5..7 are undefined and behave as an unsigned byte access.
  function automatic logic [2:0] norm_wordmode(input logic [2:0] wm);
    if (wm > wm_bs) begin
      return wm_bu;
    end
    return wm;
  endfunction

endpackage

// File: rtl/dm_arbiter_lane_unit.sv
// dm_lane_unit: combinational byte-lane logic for one latched access.
// Ports:
//   wordmode   in  3  : access size/sign (unknown codes act as wm_bu)
//   addr_lo    in  2  : byte offset within the word
//   wdata      in  32 : right-aligned store data
//   rdata      in  32 : raw RAM read word
//   byte_en    out 4  : per-lane write enable
//   wdata_rep  out 32 : store data replicated across lanes
//   rdata_ext  out 32 : selected lane, sign/zero extended
//   misaligned out 1  : word access off a word boundary or odd halfword
module dm_lane_unit
  import dm_arbiter_pkg::*;
(
  input  logic [2:0]  wordmode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [2:0]  wm;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  always_comb begin
    wm         = norm_wordmode(wordmode);
    lane_h     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    lane_b     = rdata[7:0];
    byte_en    = 4'b0000;
    wdata_rep  = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;

    case (addr_lo)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase

    case (wm)
      wm_wd: begin
        byte_en    = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
        misaligned = (addr_lo != 2'b00);
      end
      wm_hu, wm_hs: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = (wm == wm_hs) ? {{16{lane_h[15]}}, lane_h} : {16'h0000, lane_h};
        misaligned = addr_lo[0];
      end
      default: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_rep  = {4{wdata[7:0]}};
        rdata_ext  = (wm == wm_bs) ? {{24{lane_b[7]}}, lane_b} : {24'h000000, lane_b};
      end
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-port synchronous data RAM between the CPU
// data port and the boot/debug loader. Each access takes IDLE -> ISSUE ->
// RESP; the request is latched in IDLE, the RAM is strobed in ISSUE and the
// one-cycle ready pulse (with extended load data) appears in RESP.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   cpu_req/we/wordmode/addr/wdata      : CPU request (held until cpu_ready)
//   cpu_rdata/cpu_ready/cpu_err         : CPU response, valid in RESP only
//   ld_req/we/addr/wdata                : loader word request
//   ld_rdata/ld_ready                   : loader response
//   ram_en/we/addr/wdata, ram_rdata     : RAM port, 1-cycle read latency
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_wordmode,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic [31:0]       ld_rdata,
  output logic              ld_ready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_e              state_q, state_d;
  src_e                src_q, src_d;
  logic                we_q, we_d;
  logic [2:0]          wm_q, wm_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    starve_q, starve_d;

  logic                grant_ld;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_rep;
  logic [31:0]         rdata_ext;
  logic                misaligned;

  // Address bits above the RAM range wrap; loader byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

  dm_lane_unit u_lane (
    .wordmode   (wm_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (ram_rdata),
    .byte_en    (byte_en),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_CPU;
      we_q     <= 1'b0;
      wm_q     <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      we_q     <= we_d;
      wm_q     <= wm_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  // Next state, arbitration and request latch. The loader is latched as a
  // word access at a word-aligned address so the lane unit never flags it.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    we_d     = we_q;
    wm_d     = wm_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    grant_ld = ld_req && (!cpu_req || (starve_q == LIMIT_C));

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || ld_req) begin
          state_d = ST_ISSUE;
          if (grant_ld) begin
            src_d    = SRC_LD;
            we_d     = ld_we;
            wm_d     = wm_wd;
            addr_d   = {ld_addr[ADDR_W+1:2], 2'b00};
            wdata_d  = ld_wdata;
            starve_d = '0;
          end else begin
            src_d   = SRC_CPU;
            we_d    = cpu_we;
            wm_d    = cpu_wordmode;
            addr_d  = cpu_addr[ADDR_W+1:0];
            wdata_d = cpu_wdata;
            if (!ld_req) begin
              starve_d = '0;
            end else if (starve_q != LIMIT_C) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM strobes exist only in ISSUE and responses only in RESP; a
  // misaligned CPU access never touches the RAM and returns zero data.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = '0;
    ld_ready  = 1'b0;
    ld_rdata  = '0;

    case (state_q)
      ST_ISSUE: begin
        ram_en    = !misaligned;
        ram_we    = (!misaligned && we_q) ? byte_en : 4'b0000;
        ram_addr  = addr_q[ADDR_W+1:2];
        ram_wdata = wdata_rep;
      end
      ST_RESP: begin
        if (src_q == SRC_LD) begin
          ld_ready = 1'b1;
          ld_rdata = ram_rdata;
        end else begin
          cpu_ready = 1'b1;
          cpu_err   = misaligned;
          cpu_rdata = misaligned ? 32'h0 : rdata_ext;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural
// single-port RAM (read-first, 1-cycle latency, per-byte write enables).
module tb_dm_arbiter;

  localparam logic [2:0] WM_WD = 3'd0;
  localparam logic [2:0] WM_HU = 3'd1;
  localparam logic [2:0] WM_HS = 3'd2;
  localparam logic [2:0] WM_BU = 3'd3;
  localparam logic [2:0] WM_BS = 3'd4;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_wordmode;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_ready;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ramRdata;

  logic        memClear;
  logic [31:0] mem [0:4095];

  int checkCount = 0;
  int passCount  = 0;

  dm_arbiter #(.ADDR_W(12), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_wordmode (cpu_wordmode),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .cpu_err      (cpu_err),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_rdata     (ld_rdata),
    .ld_ready     (ld_ready),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read-first; memClear seeds the contents once at start-up.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[1]   <= 32'h80FF_1234;
      ramRdata <= 32'h0;
    end else if (ram_en) begin
      ramRdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [2:0] cWm,
                               input logic [31:0] cAddr, input logic [31:0] cWdata,
                               input logic lReq, input logic lWe,
                               input logic [31:0] lAddr, input logic [31:0] lWdata);
    cpu_req      = cReq;
    cpu_we       = cWe;
    cpu_wordmode = cWm;
    cpu_addr     = cAddr;
    cpu_wdata    = cWdata;
    ld_req       = lReq;
    ld_we        = lWe;
    ld_addr      = lAddr;
    ld_wdata     = lWdata;
  endtask

  task automatic dropRequests();
    applyStimulus(1'b0, 1'b0, WM_WD, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput(tag, {cpu_ready, ld_ready, cpu_err, ram_en, ram_we, ram_addr, 12'h000}, 32'h0);
    checkOutput({tag, "_data"}, cpu_rdata | ld_rdata | ram_wdata, 32'h0);
  endtask

  // Worst-case guard so the bench always ends.
  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  localparam logic [9:0] LD_TURN = 10'b10_0001_0000;

  initial begin
    reset    = 1'b1;
    memClear = 1'b1;
    dropRequests();
    tick();
    tick();
    checkQuiet("reset_outputs");
    reset    = 1'b0;
    memClear = 1'b0;
    tick();

    // Signed byte load from lane 3 of word 1.
    applyStimulus(1'b1, 1'b0, WM_BS, 32'h0000_0007, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("bs_issue_en", {31'h0, ram_en}, 32'h1);
    checkOutput("bs_issue_we", {28'h0, ram_we}, 32'h0);
    checkOutput("bs_issue_addr", {20'h0, ram_addr}, 32'h1);
    checkOutput("bs_issue_noready", {31'h0, cpu_ready}, 32'h0);
    tick();
    checkOutput("bs_resp_ready", {30'h0, cpu_ready, cpu_err}, 32'h2);
    checkOutput("bs_resp_rdata", cpu_rdata, 32'hFFFF_FF80);
    dropRequests();
    tick();
    checkQuiet("bs_back_idle");

    // Unsigned halfword store to upper half of word 1.
    applyStimulus(1'b1, 1'b1, WM_HU, 32'h0000_0006, 32'h0000_ABCD, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("hu_store_we", {28'h0, ram_we}, 32'hC);
    checkOutput("hu_store_wdata", ram_wdata, 32'hABCD_ABCD);
    tick();
    checkOutput("hu_store_ready", {30'h0, cpu_ready, cpu_err}, 32'h2);
    dropRequests();
    tick();

    // Word readback shows only the upper half changed.
    applyStimulus(1'b1, 1'b0, WM_WD, 32'h0000_0004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("wd_readback", cpu_rdata, 32'hABCD_1234);
    dropRequests();
    tick();

    // Misaligned word load: no RAM strobe, error response with zero data.
    applyStimulus(1'b1, 1'b0, WM_WD, 32'h0000_0002, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("mis_issue_en", {27'h0, ram_en, ram_we}, 32'h0);
    tick();
    checkOutput("mis_resp_flags", {30'h0, cpu_ready, cpu_err}, 32'h3);
    checkOutput("mis_resp_rdata", cpu_rdata, 32'h0);
    dropRequests();
    tick();

    // Loader word write, then CPU signed halfword load from it.
    applyStimulus(1'b0, 1'b0, WM_WD, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    checkOutput("ld_write_we", {27'h0, ram_en, ram_we}, 32'h1F);
    checkOutput("ld_write_addr", {20'h0, ram_addr}, 32'h4);
    checkOutput("ld_write_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("ld_write_ready", {30'h0, ld_ready, cpu_ready}, 32'h2);
    dropRequests();
    tick();
    applyStimulus(1'b1, 1'b0, WM_HS, 32'h0000_0012, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("hs_load_rdata", cpu_rdata, 32'hFFFF_DEAD);
    dropRequests();
    tick();

    // Loader read ignores byte offset bits.
    applyStimulus(1'b0, 1'b0, WM_WD, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    tick();
    checkOutput("ld_read_we", {27'h0, ram_en, ram_we}, 32'h10);
    tick();
    checkOutput("ld_read_rdata", ld_rdata, 32'hDEAD_BEEF);
    checkOutput("ld_read_cpu_quiet", cpu_rdata, 32'h0);
    dropRequests();
    tick();

    // Byte store lane 3, then unknown wordmode behaving as a byte store to lane 1.
    applyStimulus(1'b1, 1'b1, WM_BS, 32'h0000_0023, 32'h0000_005A, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("bs_store_we", {28'h0, ram_we}, 32'h8);
    checkOutput("bs_store_wdata", ram_wdata, 32'h5A5A_5A5A);
    tick();
    dropRequests();
    tick();
    applyStimulus(1'b1, 1'b1, 3'd7, 32'h0000_0021, 32'h0000_00C3, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("wm7_store_we", {28'h0, ram_we}, 32'h2);
    tick();
    dropRequests();
    tick();
    applyStimulus(1'b1, 1'b0, WM_WD, 32'h0000_0020, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("byte_lanes_word", cpu_rdata, 32'h5A00_C300);
    dropRequests();
    tick();
    applyStimulus(1'b1, 1'b0, WM_BU, 32'h0000_0021, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("bu_load_rdata", cpu_rdata, 32'h0000_00C3);
    dropRequests();
    tick();

    // Reset during ISSUE aborts the access; held request is re-served.
    applyStimulus(1'b1, 1'b0, WM_WD, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("abort_issue_en", {31'h0, ram_en}, 32'h1);
    reset = 1'b1;
    tick();
    checkQuiet("abort_idle");
    reset = 1'b0;
    tick();
    checkOutput("abort_reissue_en", {31'h0, ram_en}, 32'h1);
    checkOutput("abort_reissue_noready", {31'h0, cpu_ready}, 32'h0);
    tick();
    checkOutput("abort_resp_ready", {31'h0, cpu_ready}, 32'h1);
    checkOutput("abort_resp_rdata", cpu_rdata, 32'hDEAD_BEEF);
    dropRequests();
    tick();

    // Both requesters held high: CPU x4, LD, CPU x4, LD, one access per 3 cycles.
    applyStimulus(1'b1, 1'b0, WM_WD, 32'h0000_0004, 32'h0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("starve_issue_%0d", k), {30'h0, cpu_ready, ld_ready}, 32'h0);
      tick();
      checkOutput($sformatf("starve_grant_%0d", k), {30'h0, cpu_ready, ld_ready},
                  LD_TURN[k] ? 32'h1 : 32'h2);
      tick();
      checkOutput($sformatf("starve_idle_%0d", k), {30'h0, cpu_ready, ld_ready}, 32'h0);
    end
    dropRequests();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
